// File: rtl/jk_cmd_gen.sv
// -----------------------------------------------------------------------------
// jk_cmd_gen
//
// Purpose:
//   Converts a stream of desired next-state words (D-style intent) into per-bit
//   J/K excitation commands for a bank of JK flip-flops. Targets are buffered in
//   a small FIFO; a shadow copy of the driven JK bank's state is kept so that
//   each command is computed against the state the previous command leaves.
//
// Configuration:
//   JK_TOGGLE_EN  - when defined, every changing bit is encoded as a toggle
//                   (J=1, K=1). When undefined, changing bits are encoded as
//                   set (J=1, K=0) or reset (J=0, K=1); J and K never both 1.
//                   Holding bits are always J=0, K=0.
//
// Parameters:
//   WIDTH  - bits per target word and per J/K vector
//   DEPTH  - FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         in   clock, all state on rising edge
//   clr         in   asynchronous reset, active low
//   d_in        in   target next-state word
//   d_valid     in   d_in valid
//   d_ready     out  FIFO can accept (fifo_count < DEPTH), combinational
//   j_out       out  J command vector
//   k_out       out  K command vector
//   cmd_valid   out  j_out/k_out valid
//   cmd_ready   in   consumer accepts command
//   q_shadow    out  state of JK bank after last issued command
//   fifo_count  out  entries currently in the FIFO
//   chg_cnt     out  issued commands with >=1 non-hold bit, saturating
// -----------------------------------------------------------------------------
module jk_cmd_gen #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [WIDTH-1:0]               d_in,
  input  logic                           d_valid,
  output logic                           d_ready,
  output logic [WIDTH-1:0]               j_out,
  output logic [WIDTH-1:0]               k_out,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [WIDTH-1:0]               q_shadow,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic [15:0]                    chg_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // FIFO storage and pointers
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output stage
  state_t           state_q;
  logic [WIDTH-1:0] j_q, k_q, shadow_q;
  logic [15:0]      chg_q;

  // Handshake decode
  logic             push, load;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] j_cmd, k_cmd;
  logic             any_change;

  assign d_ready = (count_q < CNT_W'(DEPTH));
  assign push    = d_valid && d_ready;
  // The stage reloads when it is idle, or when its current command is taken.
  assign load    = (count_q != '0) && ((state_q == ST_EMPTY) || cmd_ready);
  assign head    = mem[rd_ptr_q];

  // Per-bit excitation against the shadow state
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef JK_TOGGLE_EN
      assign j_cmd[gi] = head[gi] ^ shadow_q[gi];
      assign k_cmd[gi] = head[gi] ^ shadow_q[gi];
`else
      assign j_cmd[gi] = head[gi] & ~shadow_q[gi];
      assign k_cmd[gi] = ~head[gi] & shadow_q[gi];
`endif
    end
  endgenerate

  assign any_change = |(j_cmd | k_cmd);

  // Pointer / occupancy next-state; pointers wrap naturally as DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, load})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Data storage carries no reset: emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= d_in;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output stage FSM with registered command outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_EMPTY;
      j_q      <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      chg_q    <= '0;
    end else begin
      if (load) begin
        state_q  <= ST_FULL;
        j_q      <= j_cmd;
        k_q      <= k_cmd;
        shadow_q <= head;
        if (any_change && (chg_q != 16'hFFFF)) chg_q <= chg_q + 16'd1;
      end else if ((state_q == ST_FULL) && cmd_ready) begin
        // Command consumed with nothing queued: J/K keep their last value.
        state_q <= ST_EMPTY;
      end
    end
  end

  assign cmd_valid  = (state_q == ST_FULL);
  assign j_out      = j_q;
  assign k_out      = k_q;
  assign q_shadow   = shadow_q;
  assign fifo_count = count_q;
  assign chg_cnt    = chg_q;

endmodule

// File: tb/tb_jk_cmd_gen.sv
module tb_jk_cmd_gen;

`ifdef JK_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic [7:0] d_in;
  logic       d_valid;
  logic       d_ready;
  logic [7:0] j_out;
  logic [7:0] k_out;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] q_shadow;
  logic [2:0] fifo_count;
  logic [15:0] chg_cnt;

  int total;
  int bad;

  jk_cmd_gen #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .d_in       (d_in),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .j_out      (j_out),
    .k_out      (k_out),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .q_shadow   (q_shadow),
    .fifo_count (fifo_count),
    .chg_cnt    (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; d_valid = 1'b0; d_in = 8'h00; cmd_ready = 1'b0;
    tick(); tick();
    total++; if (cmd_valid !== 1'b0)   begin bad++; $display("FAIL rst_cmd_valid got=%0b exp=0", cmd_valid); end
    total++; if (fifo_count !== 3'd0)  begin bad++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
    total++; if (d_ready !== 1'b1)     begin bad++; $display("FAIL rst_d_ready got=%0b exp=1", d_ready); end
    total++; if ({j_out, k_out, q_shadow} !== 24'h0) begin bad++; $display("FAIL rst_jkq got=%h/%h/%h exp=00/00/00", j_out, k_out, q_shadow); end
    total++; if (chg_cnt !== 16'h0)    begin bad++; $display("FAIL rst_chg_cnt got=%h exp=0000", chg_cnt); end
    clr = 1'b1;
    tick();
    $display("reset: cmd_valid=%0b fifo_count=%0d d_ready=%0b", cmd_valid, fifo_count, d_ready);
  endtask

  task automatic test_basic();
    cmd_ready = 1'b1;
    d_in = 8'hA5; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd1) begin bad++; $display("FAIL lat_edgeN got=cv%0b cnt%0d exp=cv0 cnt1", cmd_valid, fifo_count); end
    tick();
    total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL lat_edgeN1 got=%0b exp=1", cmd_valid); end
    total++; if (j_out !== 8'hA5 || k_out !== 8'h00) begin bad++; $display("FAIL a5_jk got=%h/%h exp=a5/00", j_out, k_out); end
    total++; if (q_shadow !== 8'hA5 || chg_cnt !== 16'd1) begin bad++; $display("FAIL a5_q_chg got=%h/%0d exp=a5/1", q_shadow, chg_cnt); end
    $display("cmd A5: j=%h k=%h q=%h chg=%0d", j_out, k_out, q_shadow, chg_cnt);
    d_in = 8'h5A; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    // Command taken with nothing queued at that edge: stage drains, J/K hold.
    total++; if (cmd_valid !== 1'b0 || j_out !== 8'hA5) begin bad++; $display("FAIL drain_hold got=cv%0b j%h exp=cv0 ja5", cmd_valid, j_out); end
    tick();
    total++; if (cmd_valid !== 1'b1 || j_out !== (TOGGLE ? 8'hFF : 8'h5A) || k_out !== (TOGGLE ? 8'hFF : 8'hA5))
      begin bad++; $display("FAIL 5a_jk got=cv%0b %h/%h exp=cv1 %h/%h", cmd_valid, j_out, k_out, TOGGLE ? 8'hFF : 8'h5A, TOGGLE ? 8'hFF : 8'hA5); end
    total++; if (q_shadow !== 8'h5A || chg_cnt !== 16'd2) begin bad++; $display("FAIL 5a_q_chg got=%h/%0d exp=5a/2", q_shadow, chg_cnt); end
    $display("cmd 5A: j=%h k=%h q=%h chg=%0d", j_out, k_out, q_shadow, chg_cnt);
  endtask

  task automatic test_back_to_back();
    cmd_ready = 1'b1;
    d_in = 8'h3C; d_valid = 1'b1;
    tick();
    tick();          // second 3C pushed, first 3C loaded
    d_valid = 1'b0;
    total++; if (j_out !== (TOGGLE ? 8'h66 : 8'h24) || k_out !== (TOGGLE ? 8'h66 : 8'h42) || chg_cnt !== 16'd3)
      begin bad++; $display("FAIL b2b_first got=%h/%h chg%0d exp=%h/%h chg3", j_out, k_out, chg_cnt, TOGGLE ? 8'h66 : 8'h24, TOGGLE ? 8'h66 : 8'h42); end
    $display("cmd 3C#1: j=%h k=%h chg=%0d", j_out, k_out, chg_cnt);
    tick();
    total++; if (cmd_valid !== 1'b1 || j_out !== 8'h00 || k_out !== 8'h00) begin bad++; $display("FAIL b2b_hold got=cv%0b %h/%h exp=cv1 00/00", cmd_valid, j_out, k_out); end
    total++; if (q_shadow !== 8'h3C || chg_cnt !== 16'd3) begin bad++; $display("FAIL b2b_q_chg got=%h/%0d exp=3c/3", q_shadow, chg_cnt); end
    $display("cmd 3C#2: j=%h k=%h chg=%0d", j_out, k_out, chg_cnt);
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", cmd_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [6];
    logic [7:0] exp_j [5];
    logic [7:0] exp_k [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    if (TOGGLE) begin
      exp_j = '{8'h2D, 8'h33, 8'h11, 8'h77, 8'h11};
      exp_k = '{8'h2D, 8'h33, 8'h11, 8'h77, 8'h11};
    end else begin
      exp_j = '{8'h01, 8'h22, 8'h11, 8'h44, 8'h11};
      exp_k = '{8'h2C, 8'h11, 8'h00, 8'h33, 8'h00};
    end
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_in = words[i]; d_valid = 1'b1;
      total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%0b exp=1", i, d_ready); end
      tick();
    end
    d_in = words[5];
    total++; if (d_ready !== 1'b0 || fifo_count !== 3'd4) begin bad++; $display("FAIL bp_full got=rdy%0b cnt%0d exp=rdy0 cnt4", d_ready, fifo_count); end
    total++; if (cmd_valid !== 1'b1 || j_out !== exp_j[0] || k_out !== exp_k[0]) begin bad++; $display("FAIL bp_cmd0 got=cv%0b %h/%h exp=cv1 %h/%h", cmd_valid, j_out, k_out, exp_j[0], exp_k[0]); end
    tick(); tick();
    total++; if (j_out !== exp_j[0] || k_out !== exp_k[0] || q_shadow !== 8'h11 || fifo_count !== 3'd4)
      begin bad++; $display("FAIL bp_stall got=%h/%h q%h cnt%0d exp=%h/%h q11 cnt4", j_out, k_out, q_shadow, fifo_count, exp_j[0], exp_k[0]); end
    $display("stall: j=%h k=%h q=%h cnt=%0d", j_out, k_out, q_shadow, fifo_count);
    d_valid = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      total++; if (cmd_valid !== 1'b1 || j_out !== exp_j[i] || k_out !== exp_k[i] || q_shadow !== words[i])
        begin bad++; $display("FAIL bp_drain%0d got=cv%0b %h/%h q%h exp=cv1 %h/%h q%h", i, cmd_valid, j_out, k_out, q_shadow, exp_j[i], exp_k[i], words[i]); end
      $display("drain %0d: j=%h k=%h q=%h", i, j_out, k_out, q_shadow);
    end
    total++; if (chg_cnt !== 16'd8) begin bad++; $display("FAIL bp_chg got=%0d exp=8", chg_cnt); end
    tick();
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL bp_empty got=cv%0b cnt%0d exp=cv0 cnt0", cmd_valid, fifo_count); end
  endtask

  task automatic test_async_reset();
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_in = 8'hA1 + 8'(i); d_valid = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    total++; if (fifo_count !== 3'd3 || cmd_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=cnt%0d cv%0b exp=cnt3 cv1", fifo_count, cmd_valid); end
    #2 clr = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || d_ready !== 1'b1)
      begin bad++; $display("FAIL ar_ctrl got=cv%0b cnt%0d rdy%0b exp=cv0 cnt0 rdy1", cmd_valid, fifo_count, d_ready); end
    total++; if (q_shadow !== 8'h00 || chg_cnt !== 16'd0 || j_out !== 8'h00 || k_out !== 8'h00)
      begin bad++; $display("FAIL ar_data got=q%h chg%0d %h/%h exp=q00 chg0 00/00", q_shadow, chg_cnt, j_out, k_out); end
    $display("async reset: cv=%0b cnt=%0d q=%h chg=%0d", cmd_valid, fifo_count, q_shadow, chg_cnt);
    tick();
    clr = 1'b1;
    cmd_ready = 1'b1;
    d_in = 8'h01; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    tick();
    total++; if (cmd_valid !== 1'b1 || j_out !== (TOGGLE ? 8'h01 : 8'h01) || k_out !== (TOGGLE ? 8'h01 : 8'h00) || chg_cnt !== 16'd1)
      begin bad++; $display("FAIL ar_after got=cv%0b %h/%h chg%0d exp=cv1 01/%h chg1", cmd_valid, j_out, k_out, chg_cnt, TOGGLE ? 8'h01 : 8'h00); end
    $display("cmd 01: j=%h k=%h chg=%0d", j_out, k_out, chg_cnt);
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ar_no_stale got=%0b exp=0", cmd_valid); end
  endtask

  task automatic test_saturation();
    bit stream_ok;
    stream_ok = 1'b1;
    cmd_ready = 1'b1;
    // chg_cnt is 1 here; 65534 alternating FF/00 words bring it exactly to FFFF.
    for (int i = 0; i < 65534; i++) begin
      d_in = (i % 2 == 0) ? 8'hFF : 8'h00;
      d_valid = 1'b1;
      if (d_ready !== 1'b1) stream_ok = 1'b0;
      tick();
    end
    d_valid = 1'b0;
    tick();
    total++; if (stream_ok !== 1'b1) begin bad++; $display("FAIL sat_stream got=%0b exp=1", stream_ok); end
    total++; if (chg_cnt !== 16'hFFFF || q_shadow !== 8'h00) begin bad++; $display("FAIL sat_reach got=%h q%h exp=ffff q00", chg_cnt, q_shadow); end
    $display("saturate: chg=%h q=%h", chg_cnt, q_shadow);
    d_in = 8'hFF; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    tick();
    total++; if (chg_cnt !== 16'hFFFF || j_out !== 8'hFF || k_out !== (TOGGLE ? 8'hFF : 8'h00))
      begin bad++; $display("FAIL sat_hold got=%h %h/%h exp=ffff ff/%h", chg_cnt, j_out, k_out, TOGGLE ? 8'hFF : 8'h00); end
    $display("saturate +1: chg=%h j=%h k=%h", chg_cnt, j_out, k_out);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
